// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_TIME  = 2'd0,
    MODE_ALARM = 2'd1,
    MODE_EDIT  = 2'd2
  } mode_e;

  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HOUR = 6'd23;

  localparam logic [1:0] EDIT_NONE = 2'b00;
  localparam logic [1:0] EDIT_MIN  = 2'b01;
  localparam logic [1:0] EDIT_HOUR = 2'b10;
  localparam logic [1:0] EDIT_BOTH = 2'b11;

  localparam logic [3:0] ALL_ON = 4'b1111;

endpackage

// File: rtl/display_scheduler_scan_timer.sv
// Scan prescaler and 3-bit phase counter; fb marks the last cycle of phase 7.
module scan_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] byte_status,
  output logic       fb
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_phase;
  logic          w_tc;

  assign w_tc        = (r_pcnt == PCNT_LAST);
  assign fb          = w_tc && (r_phase == 3'd7);
  assign byte_status = r_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pcnt  <= '0;
      r_phase <= '0;
    end else begin
      r_pcnt <= w_tc ? '0 : r_pcnt + 1'b1;
      if (w_tc) r_phase <= r_phase + 3'd1;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Frame-synchronous mode arbitration, snapshot/clamp and alarm-edit blink mask.
//   state      | meaning
//   MODE_TIME  | showing time_data, mask all on
//   MODE_ALARM | showing alarm_data, mask all on
//   MODE_EDIT  | showing alarm_data, edited field blinks every BLINK_FRAMES frames
module display_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] time_data,
  input  logic [11:0] alarm_data,
  input  logic        show_alarm,
  input  logic [1:0]  edit_field,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [3:0]  digit_mask,
  output logic        frame_start,
  output logic        range_err
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

  mode_e         r_state;
  logic [BW-1:0] r_bcnt;
  logic          r_blink_on;

  logic          w_fb;
  mode_e         w_next_state;
  logic [11:0]   w_src;
  logic          w_min_bad;
  logic          w_hour_bad;
  logic [BW-1:0] w_next_bcnt;
  logic          w_next_blink;
  logic [3:0]    w_next_mask;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
    .clock       (clock),
    .reset       (reset),
    .byte_status (byte_status),
    .fb          (w_fb)
  );

  always_comb begin
    w_next_state = MODE_TIME;
    if (edit_field != EDIT_NONE) w_next_state = MODE_EDIT;
    else if (show_alarm)         w_next_state = MODE_ALARM;
  end

  assign w_src      = (w_next_state == MODE_TIME) ? time_data : alarm_data;
  assign w_min_bad  = (w_src[5:0]  > MAX_MIN);
  assign w_hour_bad = (w_src[11:6] > MAX_HOUR);

  // Blink phase restarts visible on every fresh entry into EDIT.
  always_comb begin
    w_next_bcnt  = '0;
    w_next_blink = 1'b1;
    if (w_next_state == MODE_EDIT && r_state == MODE_EDIT) begin
      if (r_bcnt == BCNT_LAST) begin
        w_next_bcnt  = '0;
        w_next_blink = ~r_blink_on;
      end else begin
        w_next_bcnt  = r_bcnt + 1'b1;
        w_next_blink = r_blink_on;
      end
    end
  end

  always_comb begin
    w_next_mask = ALL_ON;
    if (w_next_state == MODE_EDIT && !w_next_blink) begin
      case (edit_field)
        EDIT_MIN:  w_next_mask = 4'b1100;
        EDIT_HOUR: w_next_mask = 4'b0011;
        EDIT_BOTH: w_next_mask = 4'b0000;
        default:   w_next_mask = ALL_ON;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= MODE_TIME;
      r_bcnt      <= '0;
      r_blink_on  <= 1'b1;
      data_show   <= '0;
      digit_mask  <= ALL_ON;
      frame_start <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      frame_start <= w_fb;
      if (w_fb) begin
        r_state    <= w_next_state;
        r_bcnt     <= w_next_bcnt;
        r_blink_on <= w_next_blink;
        data_show  <= {w_hour_bad ? 6'd0 : w_src[11:6], w_min_bad ? 6'd0 : w_src[5:0]};
        range_err  <= w_min_bad || w_hour_bad;
        digit_mask <= w_next_mask;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized self-checking bench for display_scheduler against a frame-level model.
module tb_display_scheduler;

  localparam int SD = 2;
  localparam int BF = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] time_data = '0;
  logic [11:0] alarm_data = '0;
  logic        show_alarm = 1'b0;
  logic [1:0]  edit_field = 2'b00;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic [3:0]  digit_mask;
  logic        frame_start;
  logic        range_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  display_scheduler #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clock       (clock),
    .reset       (reset_n),
    .time_data   (time_data),
    .alarm_data  (alarm_data),
    .show_alarm  (show_alarm),
    .edit_field  (edit_field),
    .data_show   (data_show),
    .byte_status (byte_status),
    .digit_mask  (digit_mask),
    .frame_start (frame_start),
    .range_err   (range_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_n = 0;     // clock edges since reset release
  int         m_run = 0;   // consecutive frames spent in edit
  logic [11:0] m_data = '0;
  logic [3:0]  m_mask = 4'hF;
  logic        m_fs = 1'b0;
  logic        m_err = 1'b0;

  function automatic bit is_fb(input int n);
    return ((n % SD) == SD - 1) && (((n / SD) % 8) == 7);
  endfunction

  function automatic logic [11:0] clamp_hm(input logic [11:0] v);
    int h, m;
    h = int'(v[11:6]);
    m = int'(v[5:0]);
    if (h > 23) h = 0;
    if (m > 59) m = 0;
    return 12'(h * 64 + m);
  endfunction

  function automatic logic out_of_range(input logic [11:0] v);
    return (int'(v[11:6]) > 23) || (int'(v[5:0]) > 59);
  endfunction

  function automatic logic [3:0] mask_of(input logic [1:0] ed, input int run);
    logic [3:0] off;
    if (ed == 2'b00) return 4'hF;
    if (((run - 1) / BF) % 2 == 0) return 4'hF;
    off = {ed[1], ed[1], ed[0], ed[0]};
    return ~off;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_n    <= 0;
      m_run  <= 0;
      m_data <= '0;
      m_mask <= 4'hF;
      m_fs   <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_n  <= m_n + 1;
      m_fs <= is_fb(m_n);
      if (is_fb(m_n)) begin
        m_data <= clamp_hm((edit_field != 2'b00 || show_alarm) ? alarm_data : time_data);
        m_err  <= out_of_range((edit_field != 2'b00 || show_alarm) ? alarm_data : time_data);
        m_run  <= (edit_field != 2'b00) ? m_run + 1 : 0;
        m_mask <= mask_of(edit_field, m_run + 1);
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("byte_status", 32'(byte_status), 32'((m_n / SD) % 8));
      chk("data_show",   32'(data_show),   32'(m_data));
      chk("digit_mask",  32'(digit_mask),  32'(m_mask));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
      chk("range_err",   32'(range_err),   32'(m_err));
    end
  end

  // ---------------- helpers ----------------
  task automatic sync_frame();
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!frame_start && k < 40);
    if (!frame_start) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no frame_start within 40 cycles, got %0b expected 1", frame_start);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (byte_status != p && k < 40);
    if (byte_status != p) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout: got %0d expected %0d", byte_status, p);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bs"},   32'(byte_status), 32'd0);
    chk({tag, "_data"}, 32'(data_show),   32'd0);
    chk({tag, "_mask"}, 32'(digit_mask),  32'hF);
    chk({tag, "_fs"},   32'(frame_start), 32'd0);
    chk({tag, "_err"},  32'(range_err),   32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] blink_exp [6];

  initial begin
    int cnt;
    blink_exp[0] = 4'hF; blink_exp[1] = 4'hF;
    blink_exp[2] = 4'hC; blink_exp[3] = 4'hC;
    blink_exp[4] = 4'hF; blink_exp[5] = 4'hF;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("reset");
    chk_en = 1;
    reset_n = 1'b1;

    // scan cadence and frame period
    sync_frame();
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!frame_start && cnt < 40);
    chk("frame_period", 32'(cnt), 32'd16);

    // time display
    time_data = {6'd12, 6'd34};
    sync_frame();
    chk("time_show", 32'(data_show), 32'h322);
    chk("time_mask", 32'(digit_mask), 32'hF);
    chk("time_err",  32'(range_err), 32'd0);

    // no mid-frame tearing
    alarm_data = {6'd7, 6'd5};
    wait_phase(3'd3);
    show_alarm = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (!frame_start && cnt < 40) begin
      chk("no_tear", 32'(data_show), 32'h322);
      @(negedge clock);
      cnt++;
    end
    chk("alarm_show", 32'(data_show), 32'h1C5);

    // range clamp
    show_alarm = 1'b0;
    time_data  = {6'd30, 6'd61};
    sync_frame();
    chk("clamp_data", 32'(data_show), 32'd0);
    chk("clamp_err",  32'(range_err), 32'd1);
    time_data = {6'd1, 6'd2};
    sync_frame();
    chk("legal_data", 32'(data_show), 32'h042);
    chk("legal_err",  32'(range_err), 32'd0);

    // blink in edit, edit wins over alarm
    edit_field = 2'b01;
    show_alarm = 1'b1;
    for (int f = 0; f < 6; f++) begin
      sync_frame();
      chk($sformatf("blink_f%0d", f + 1), 32'(digit_mask), 32'(blink_exp[f]));
    end
    chk("edit_data", 32'(data_show), 32'h1C5);
    edit_field = 2'b00;
    sync_frame();
    chk("edit_exit_mask", 32'(digit_mask), 32'hF);

    // reset during phase 5 in edit
    edit_field = 2'b11;
    sync_frame();
    sync_frame();
    sync_frame();
    chk("both_mask", 32'(digit_mask), 32'h0);
    wait_phase(3'd5);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midreset");
    edit_field = 2'b00;
    show_alarm = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("restart_bs", 32'(byte_status), 32'd0);
    sync_frame();
    chk("restart_data", 32'(data_show), 32'h042);
    chk("restart_mask", 32'(digit_mask), 32'hF);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(1, 12)) @(negedge clock);
      case ($urandom_range(0, 3))
        0: time_data  = 12'($urandom);
        1: alarm_data = 12'($urandom);
        2: show_alarm = 1'($urandom);
        default: edit_field = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      endcase
    end
    repeat (20) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
